// File: rtl/aes_inv_round_iter.sv
// Iterative AES inverse cipher: one inverse round per clock.
// Round keys come from an external store, consumed last to first.
//
// Ports:
//   i_clock, i_reset_n   clock, async active-low reset
//   i_data/i_valid       ciphertext in, o_ready back-pressure
//   i_abort              drop the block in flight
//   o_key_idx            round-key index for this cycle
//   i_round_key          key for o_key_idx, same cycle
//   o_data/o_valid       plaintext out, i_ready accepts it
`timescale 1ns/1ps

module inv_shiftrows_block (
  input  logic [127:0] data_i,
  output logic [127:0] data_o
);
  // Row r rotates right by r: out[r][c] = in[r][c-r].
  for (genvar c = 0; c < 4; c++) begin : g_col
    for (genvar r = 0; r < 4; r++) begin : g_row
      assign data_o[127-8*(4*c+r) -: 8] =
        data_i[127-8*(4*((c+4-r)%4)+r) -: 8];
    end
  end
endmodule

module inv_subbytes_block (
  input  logic [127:0] data_i,
  output logic [127:0] data_o
);
  localparam logic [0:255][7:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb,
    128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e,
    128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692,
    128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506,
    128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673,
    128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b,
    128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f,
    128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961,
    128'h172b047eba77d626e169146355210c7d
  };

  for (genvar i = 0; i < 16; i++) begin : g_byte
    assign data_o[127-8*i -: 8] =
      INV_SBOX[data_i[127-8*i -: 8]];
  end
endmodule

module inv_mixcolumns_block (
  input  logic [127:0] data_i,
  output logic [127:0] data_o
);
  function automatic logic [7:0] xt(
    input logic [7:0] a
  );
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  // 09/0B/0D/0E built from one x2 -> x4 -> x8 chain.
  function automatic logic [31:0] mix_col(
    input logic [31:0] col
  );
    logic [7:0] a, x2, x4, x8;
    logic [7:0] m9 [4];
    logic [7:0] mb [4];
    logic [7:0] md [4];
    logic [7:0] me [4];
    for (int k = 0; k < 4; k++) begin
      a = col[31-8*k -: 8];
      x2 = xt(a);
      x4 = xt(x2);
      x8 = xt(x4);
      m9[k] = x8 ^ a;
      mb[k] = x8 ^ x2 ^ a;
      md[k] = x8 ^ x4 ^ a;
      me[k] = x8 ^ x4 ^ x2;
    end
    return {
      me[0] ^ mb[1] ^ md[2] ^ m9[3],
      m9[0] ^ me[1] ^ mb[2] ^ md[3],
      md[0] ^ m9[1] ^ me[2] ^ mb[3],
      mb[0] ^ md[1] ^ m9[2] ^ me[3]
    };
  endfunction

  for (genvar c = 0; c < 4; c++) begin : g_col
    assign data_o[127-32*c -: 32] =
      mix_col(data_i[127-32*c -: 32]);
  end
endmodule

module aes_inv_round_iter #(
  parameter int NB_BYTE  = 8,
  parameter int N_BYTES  = 16,
  parameter int N_ROUNDS = 14,
  parameter int NB_RIDX  = 4
) (
  input  logic                       i_clock,
  input  logic                       i_reset_n,
  input  logic [NB_BYTE*N_BYTES-1:0] i_data,
  input  logic                       i_valid,
  output logic                       o_ready,
  input  logic                       i_abort,
  output logic [NB_RIDX-1:0]         o_key_idx,
  input  logic [NB_BYTE*N_BYTES-1:0] i_round_key,
  output logic [NB_BYTE*N_BYTES-1:0] o_data,
  output logic                       o_valid,
  input  logic                       i_ready
);
  localparam int NB = NB_BYTE * N_BYTES;

  if ((N_ROUNDS != 10 && N_ROUNDS != 12 &&
       N_ROUNDS != 14) || NB_BYTE != 8 ||
      N_BYTES != 16 || NB_RIDX < 4) begin : BAD_CONF
    $error("aes_inv_round_iter: bad configuration");
  end

  localparam logic [NB_RIDX-1:0] KLAST =
    NB_RIDX'(N_ROUNDS);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } fsm_e;

  fsm_e             fsm_q, fsm_d;
  logic [NB-1:0]    state_q, state_d;
  logic [NB-1:0]    data_q, data_d;
  logic [NB_RIDX-1:0] rcnt_q, rcnt_d;
  logic             valid_q, valid_d;

  logic [NB-1:0] isr, isb, ark, imc;

  inv_shiftrows_block u_isr (
    .data_i (state_q),
    .data_o (isr)
  );

  inv_subbytes_block u_isb (
    .data_i (isr),
    .data_o (isb)
  );

  // Key is added before InvMixColumns, as in
  // the straight (non-equivalent) inverse cipher.
  assign ark = isb ^ i_round_key;

  inv_mixcolumns_block u_imc (
    .data_i (ark),
    .data_o (imc)
  );

  always_comb begin
    fsm_d     = fsm_q;
    state_d   = state_q;
    data_d    = data_q;
    rcnt_d    = rcnt_q;
    valid_d   = valid_q;
    o_ready   = 1'b0;
    o_key_idx = '0;
    unique case (1'b1)
      (fsm_q == IDLE): begin
        o_ready   = 1'b1;
        o_key_idx = KLAST;
        if (i_valid && !i_abort) begin
          state_d = i_data ^ i_round_key;
          rcnt_d  = KLAST - 1'b1;
          fsm_d   = RUN;
        end
      end
      (fsm_q == RUN): begin
        o_key_idx = rcnt_q;
        if (i_abort) begin
          fsm_d = IDLE;
        end else if (rcnt_q != '0) begin
          state_d = imc;
          rcnt_d  = rcnt_q - 1'b1;
        end else begin
          state_d = ark;
          data_d  = ark;
          valid_d = 1'b1;
          fsm_d   = DONE;
        end
      end
      (fsm_q == DONE): begin
        if (i_abort || i_ready) begin
          valid_d = 1'b0;
          fsm_d   = IDLE;
        end
      end
      default: begin
        valid_d = 1'b0;
        fsm_d   = IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      fsm_q   <= IDLE;
      state_q <= '0;
      data_q  <= '0;
      rcnt_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      fsm_q   <= fsm_d;
      state_q <= state_d;
      data_q  <= data_d;
      rcnt_q  <= rcnt_d;
      valid_q <= valid_d;
    end
  end

  assign o_valid = valid_q;
  assign o_data  = data_q;

endmodule
